risc_exec_sequencer: RTL and testbench
======================================

// Module: risc_exec_sequencer
// PURPOSE
//  Multicycle fetch/decode/execute sequencer for the 8-bit RISC MCU; directly upstream of the ALU.
//  Holds PC, IR, ADD_R, Z flag and a 4x8 register file. Drives ALU operands and opcode, writes back alu_out.
//  Fetches 1- or 2-byte instructions from a synchronous single-port memory (read data valid 1 cycle after address).
// PARAMETERS
//  DATA_W  8  data, address and instruction byte width
//  OP_W    4  opcode width (matches ALU sel)
//  NREG    4  register file depth (2-bit src/dest fields)
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous, active-low reset
//  mem_addr       out  DATA_W  memory address
//  mem_rdata      in   DATA_W  memory read data; valid the cycle after mem_addr
//  mem_wdata      out  DATA_W  memory write data
//  mem_we         out  1       write strobe; one cycle per STORE
//  alu_data_1     out  DATA_W  R[dest]
//  alu_data_2     out  DATA_W  R[src]
//  alu_sel        out  OP_W    IR[7:4]
//  alu_out        in   DATA_W  ALU result (combinational)
//  alu_zero_flag  in   1       ALU zero flag
//  halted         out  1       sequencer is in S_HALT
// BEHAVIOUR
//  Instruction byte = {op[7:4], src[3:2], dest[1:0]}. Second byte (LOAD/STORE/JUMP/JZ) = address.
//  Opcodes: 0 ADD R[d]<=R[d]+R[s]; 1 SUB R[d]<=R[s]-R[d]; 2 AND; 3 OR; 4 NOT R[d]<=~R[s]; 5 NOP/illegal;
//    6 JUMP; 7 JZ (taken iff Z=1); 8-9 STORE mem[addr]<=R[s]; 10-11 LOAD R[d]<=mem[addr]; 12-15 HALT.
//  States and mem_addr: S_FET1 (PC) -> S_FET2 (IR<=mem_rdata, PC++) -> S_DEC.
//  S_DEC on opcode 0-4: R[d]<=alu_out, Z<=alu_zero_flag -> S_FET1. Z changes only on opcodes 0-4.
//  S_DEC on 5 -> S_FET1. On 6/7 -> S_BR1. On 8-11 -> S_AD1. On 12-15 -> S_HALT.
//  S_BR1 (PC) -> S_BR2: PC<=taken ? mem_rdata : PC+1 -> S_FET1.
//  S_AD1 (PC) -> S_AD2: ADD_R<=mem_rdata, PC++; then LOAD -> S_LD1, STORE -> S_ST.
//  S_LD1 (ADD_R) -> S_LD2: R[d]<=mem_rdata -> S_FET1.
//  S_ST: mem_addr=ADD_R, mem_wdata=R[s], mem_we=1 -> S_FET1.
//  S_HALT: absorbing until reset; halted=1, mem_we=0, no register writes.
//  Latency from S_FET1 to next S_FET1: ALU/NOP 3 cycles, JUMP/JZ 5, STORE 6, LOAD 7.
//  mem_addr is combinational from state; mem_addr = PC in S_DEC and S_HALT.
//  Arithmetic: PC wraps 0xFF->0x00 modulo 2^DATA_W. A 2-byte instruction at 0xFF takes its operand from 0x00.
//  ALU result is truncated to DATA_W bits; no carry is kept.
//  Reset values: state=S_FET1, PC=0, IR=0, ADD_R=0, R0..R3=0, Z=0, mem_we=0, halted=0.
//    mem_addr=0, mem_wdata=0, alu_data_1=0, alu_data_2=0, alu_sel=0.
//  Reset mid-instruction aborts the instruction; no partial write-back; mem_we deasserts asynchronously.
//  src==dest is legal; the operand is read before the write (same-edge read-before-write).
// CONFIGURATION
//  Macro ILLEGAL_TRAP_EN.
//  Defined: opcode 5 -> S_HALT, and output illegal_op (1 bit) is registered high until reset.
//  Undefined: opcode 5 is a 3-cycle NOP, and the illegal_op port does not exist.
// STRUCTURE
//  Package risc_pkg: DATA_W/OP_W constants; opcode localparams (OP_ADD..OP_HALT_BASE); state enum.
//  The ALU instance shares the opcode localparams from risc_pkg.
//  Sub-module risc_reg_file: 4xDATA_W, 2 async read ports, 1 sync write port, async active-low clear.
// TESTING
//  1 Reset: rst_n low 3 cycles, then release -> mem_addr=0x00 in the first cycle, mem_we=0, halted=0.
//  2 Program LOAD R1,[0x80]=0x55; LOAD R2,[0x81]=0x0F; ADD(0x09); STORE R1,[0x82] (0x84,0x82)
//    -> mem[0x82]=0x64; mem_we high exactly 1 cycle; cycle counts 7+7+3+6.
//  3 R1=R2=0x0F, SUB(0x19) -> R1=0x00, Z=1; JZ 0x40 -> next fetch at 0x40.
//    Z=0 case -> fetch at PC+2.
//  4 JUMP 0xFF; mem[0xFF]=NOP(0x50) -> next fetch at 0x00 (PC wrap).
//  5 HALT(0xC0) -> halted=1 held 20 cycles, no mem_we.
//    Assert rst_n mid-LOAD at S_LD1 -> R[d] unchanged, fetch restarts at 0x00.
//  6 With ILLEGAL_TRAP_EN, 0x50 -> illegal_op=1 and halted=1.
//    Without it, 0x50 -> PC advances by 1 after 3 cycles.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared constants, opcode map and sequencer state encoding for the 8-bit RISC MCU.
// The same opcode localparams are used by the ALU that sits downstream of the sequencer.
package risc_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int NREG   = 4;
  localparam int REG_AW = $clog2(NREG);

  localparam logic [OP_W-1:0] OP_ADD       = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB       = 4'd1;
  localparam logic [OP_W-1:0] OP_AND       = 4'd2;
  localparam logic [OP_W-1:0] OP_OR        = 4'd3;
  localparam logic [OP_W-1:0] OP_NOT       = 4'd4;
  localparam logic [OP_W-1:0] OP_NOP       = 4'd5;
  localparam logic [OP_W-1:0] OP_JUMP      = 4'd6;
  localparam logic [OP_W-1:0] OP_JZ        = 4'd7;
  localparam logic [OP_W-1:0] OP_STORE     = 4'd8;
  localparam logic [OP_W-1:0] OP_LOAD      = 4'd10;
  localparam logic [OP_W-1:0] OP_HALT_BASE = 4'd12;

  typedef enum logic [3:0] {
    S_FET1,
    S_FET2,
    S_DEC,
    S_BR1,
    S_BR2,
    S_AD1,
    S_AD2,
    S_LD1,
    S_LD2,
    S_ST,
    S_HALT
  } state_t;

  // Opcodes 0..4 go through the ALU and update the Z flag.
  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op <= OP_NOT;
  endfunction

endpackage

// File: rtl/risc_reg_file.sv
// 4 x DATA_W register file: two asynchronous read ports, one synchronous write port,
// asynchronous active-low clear. Reads see the old value on a same-edge write.
module risc_reg_file
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              we,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/risc_exec_sequencer.sv
// Multicycle fetch/decode/execute sequencer feeding the ALU of the 8-bit RISC MCU.
// Optional build macro ILLEGAL_TRAP_EN: opcode 5 halts the core and raises illegal_op.
module risc_exec_sequencer
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] alu_data_1,
  output logic [DATA_W-1:0] alu_data_2,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero_flag,
`ifdef ILLEGAL_TRAP_EN
  output logic              illegal_op,
`endif
  output logic              halted
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t            state, state_next;
  logic [DATA_W-1:0] pc, pc_next;
  logic [DATA_W-1:0] ir, ir_next;
  logic [DATA_W-1:0] add_r, add_r_next;
  logic              z, z_next;

  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] src, dest;
  logic [DATA_W-1:0] r_dest, r_src;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

`ifdef ILLEGAL_TRAP_EN
  logic trap_set;
  logic illegal_q;
`endif

  assign op   = ir[DATA_W-1 -: OP_W];
  assign src  = ir[2*REG_AW-1 -: REG_AW];
  assign dest = ir[REG_AW-1:0];

  risc_reg_file u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (dest),
    .rd_addr_b (src),
    .rd_data_a (r_dest),
    .rd_data_b (r_src),
    .we        (rf_we),
    .wr_addr   (dest),
    .wr_data   (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FET1;
      pc    <= '0;
      ir    <= '0;
      add_r <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
      add_r <= add_r_next;
      z     <= z_next;
    end
  end

  // Memory is synchronous: the byte addressed in one state arrives on mem_rdata
  // in the following state, so every read is a pair of states (FET1/FET2, BR1/BR2, ...).
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    add_r_next = add_r;
    z_next     = z;
    rf_we      = 1'b0;
    rf_wdata   = alu_out;
`ifdef ILLEGAL_TRAP_EN
    trap_set   = 1'b0;
`endif
    case (state)
      S_FET1: state_next = S_FET2;
      S_FET2: begin
        ir_next    = mem_rdata;
        pc_next    = pc + ONE;
        state_next = S_DEC;
      end
      S_DEC: begin
        if (is_alu_op(op)) begin
          rf_we      = 1'b1;
          z_next     = alu_zero_flag;
          state_next = S_FET1;
        end else if (op == OP_NOP) begin
`ifdef ILLEGAL_TRAP_EN
          trap_set   = 1'b1;
          state_next = S_HALT;
`else
          state_next = S_FET1;
`endif
        end else if (op <= OP_JZ) begin
          state_next = S_BR1;
        end else if (op < OP_HALT_BASE) begin
          state_next = S_AD1;
        end else begin
          state_next = S_HALT;
        end
      end
      S_BR1: state_next = S_BR2;
      S_BR2: begin
        pc_next    = ((op == OP_JUMP) || z) ? mem_rdata : pc + ONE;
        state_next = S_FET1;
      end
      S_AD1: state_next = S_AD2;
      S_AD2: begin
        add_r_next = mem_rdata;
        pc_next    = pc + ONE;
        state_next = (op >= OP_LOAD) ? S_LD1 : S_ST;
      end
      S_LD1: state_next = S_LD2;
      S_LD2: begin
        rf_we      = 1'b1;
        rf_wdata   = mem_rdata;
        state_next = S_FET1;
      end
      S_ST:   state_next = S_FET1;
      S_HALT: state_next = S_HALT;
      default: state_next = S_FET1;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
    end else if (trap_set) begin
      illegal_q <= 1'b1;
    end
  end

  assign illegal_op = illegal_q;
`endif

  // Data-phase states address the operand latched in ADD_R; everything else points at PC.
  assign mem_addr   = ((state == S_LD1) || (state == S_LD2) || (state == S_ST)) ? add_r : pc;
  assign mem_we     = (state == S_ST);
  assign mem_wdata  = (state == S_ST) ? r_src : '0;
  assign alu_data_1 = r_dest;
  assign alu_data_2 = r_src;
  assign alu_sel    = op;
  assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_risc_exec_sequencer.sv
// Scoreboard bench for risc_exec_sequencer: an ISA-level model predicts every store
// (cycle, address, data) and the halt cycle; a monitor checks stores as they appear.
module tb_risc_exec_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem_addr, mem_rdata, mem_wdata;
  logic       mem_we;
  logic [7:0] alu_data_1, alu_data_2, alu_out;
  logic [3:0] alu_sel;
  logic       alu_zero_flag;
  logic       halted;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int n_pass = 0;
  int n_total = 0;
  int cyc;

  logic [7:0]  mem [256];
  logic [7:0]  img [256];
  logic        load_img = 1'b0;
  logic [31:0] exp_q [$];
  int          exp_halt_cyc;
  logic        exp_trap;

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (load_img) mem <= img;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  always_comb begin
    case (alu_sel)
      4'd0:    alu_out = alu_data_1 + alu_data_2;
      4'd1:    alu_out = alu_data_2 - alu_data_1;
      4'd2:    alu_out = alu_data_1 & alu_data_2;
      4'd3:    alu_out = alu_data_1 | alu_data_2;
      4'd4:    alu_out = ~alu_data_2;
      default: alu_out = 8'h00;
    endcase
  end
  assign alu_zero_flag = (alu_out == 8'h00);

  risc_exec_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .alu_data_1    (alu_data_1),
    .alu_data_2    (alu_data_2),
    .alu_sel       (alu_sel),
    .alu_out       (alu_out),
    .alu_zero_flag (alu_zero_flag),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op    (illegal_op),
`endif
    .halted        (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL store_unexpected: got addr %0h data %0h at cycle %0d, expected no store",
                 mem_addr, mem_wdata, cyc);
      end else begin
        chk("store", {16'(cyc), mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- ISA reference model ----------------
  task automatic run_model();
    logic [7:0] m [256];
    logic [7:0] r [4];
    logic [7:0] pc, pc1, ir, a, res;
    logic [3:0] op;
    logic [1:0] s, d;
    logic       z;
    int         t;
    m = img;
    r = '{default: 8'h00};
    pc = 8'h00;
    z = 1'b0;
    t = 0;
    exp_q.delete();
    exp_trap = 1'b0;
    exp_halt_cyc = -1;
    for (int step = 0; step < 4000; step++) begin
      ir  = m[pc];
      op  = ir[7:4];
      s   = ir[3:2];
      d   = ir[1:0];
      pc1 = pc + 8'd1;
      a   = m[pc1];
      if (op <= 4'd4) begin
        case (op)
          4'd0:    res = r[d] + r[s];
          4'd1:    res = r[s] - r[d];
          4'd2:    res = r[d] & r[s];
          4'd3:    res = r[d] | r[s];
          default: res = ~r[s];
        endcase
        r[d] = res;
        z = (res == 8'h00);
        pc = pc + 8'd1;
        t += 3;
      end else if (op == 4'd5) begin
`ifdef ILLEGAL_TRAP_EN
        exp_trap = 1'b1;
        exp_halt_cyc = t + 3;
        return;
`else
        pc = pc + 8'd1;
        t += 3;
`endif
      end else if (op <= 4'd7) begin
        pc = ((op == 4'd6) || z) ? a : pc + 8'd2;
        t += 5;
      end else if (op <= 4'd9) begin
        exp_q.push_back({16'(t + 5), a, r[s]});
        m[a] = r[s];
        pc = pc + 8'd2;
        t += 6;
      end else if (op <= 4'd11) begin
        r[d] = m[a];
        pc = pc + 8'd2;
        t += 7;
      end else begin
        exp_halt_cyc = t + 3;
        return;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'hC0;
  endtask

  task automatic start_prog();
    run_model();
    load_img = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({mem_addr, mem_we, halted, alu_sel, alu_data_1, alu_data_2, mem_wdata}), 32'h0);
    load_img = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("fetch_start_addr", 32'(mem_addr), 32'h00);
  endtask

  task automatic finish_prog(input int hold);
    bit seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(negedge clk);
      if (halted) seen = 1'b1;
    end
    chk("halt_seen", 32'(seen), 32'h1);
    chk("halt_cycle", 32'(cyc), 32'(exp_halt_cyc));
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_op", 32'(illegal_op), 32'(exp_trap));
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("halt_hold", 32'({halted, mem_we}), 32'h2);
    end
    repeat (2) @(negedge clk);
    chk("stores_drained", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic gen_random();
    int pos = 0;
    int k, skip;
    logic [3:0] sd;
    clear_img();
    for (int i = 128; i < 224; i++) img[i] = 8'($urandom);
    while (pos < 100) begin
      k  = $urandom_range(0, 9);
      sd = 4'($urandom);
      if (k <= 3) begin
        img[pos] = {4'($urandom_range(0, 4)), sd};
        pos += 1;
      end else if (k == 4) begin
        img[pos] = {4'd5, sd};
        pos += 1;
      end else if (k <= 6) begin
        skip = $urandom_range(0, 2);
        img[pos] = {4'($urandom_range(6, 7)), sd};
        img[pos+1] = 8'(pos + 2 + skip);
        pos += 2 + skip;
      end else if (k == 7) begin
        img[pos] = {4'($urandom_range(8, 9)), sd};
        img[pos+1] = 8'($urandom_range(192, 223));
        pos += 2;
      end else begin
        img[pos] = {4'($urandom_range(10, 11)), sd};
        img[pos+1] = 8'($urandom_range(128, 223));
        pos += 2;
      end
    end
    for (int i = 0; i < 4; i++) begin
      img[pos] = {4'd8, 2'(i), 2'd0};
      img[pos+1] = 8'(224 + i);
      pos += 2;
    end
    img[pos] = {4'($urandom_range(12, 15)), 4'($urandom)};
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // LOAD/LOAD/ADD/STORE with known result
    clear_img();
    img[0] = 8'hA1; img[1] = 8'h80; img[2] = 8'hA2; img[3] = 8'h81;
    img[4] = 8'h09; img[5] = 8'h84; img[6] = 8'h82; img[7] = 8'hC0;
    img[8'h80] = 8'h55; img[8'h81] = 8'h0F;
    start_prog();
    finish_prog(0);
    chk("prog2_mem82", 32'(mem[8'h82]), 32'h64);

    // SUB to zero then JZ taken; then nonzero and JZ not taken
    for (int pass = 0; pass < 2; pass++) begin
      clear_img();
      img[0] = 8'hA1; img[1] = 8'h80; img[2] = 8'hA2; img[3] = 8'h81;
      img[4] = 8'h19; img[5] = 8'h70; img[6] = 8'h40;
      img[7] = 8'h84; img[8] = 8'hE1; img[9] = 8'hC0;
      img[8'h40] = 8'h84; img[8'h41] = 8'hE0; img[8'h42] = 8'hC0;
      img[8'h80] = 8'h0F;
      img[8'h81] = (pass == 0) ? 8'h0F : 8'h10;
      img[8'hE0] = 8'hAA; img[8'hE1] = 8'hAA;
      start_prog();
      finish_prog(0);
      if (pass == 0) chk("jz_taken_store", 32'({mem[8'hE0], mem[8'hE1]}), 32'h00AA);
      else           chk("jz_fall_store", 32'({mem[8'hE0], mem[8'hE1]}), 32'hAA01);
    end

    // JUMP to 0xFF, NOP there, PC wraps to 0x00
    clear_img();
    img[0] = 8'h70; img[1] = 8'h20; img[2] = 8'h10; img[3] = 8'h60; img[4] = 8'hFF;
    img[8'hFF] = 8'h50;
    img[8'h20] = 8'hA1; img[8'h21] = 8'h80; img[8'h22] = 8'h84; img[8'h23] = 8'hE0;
    img[8'h80] = 8'h77;
    start_prog();
    finish_prog(0);
`ifndef ILLEGAL_TRAP_EN
    chk("wrap_store", 32'(mem[8'hE0]), 32'h77);
`endif

    // NOP/illegal as the first instruction, then a store
    clear_img();
    img[0] = 8'h50; img[1] = 8'h80; img[2] = 8'hE0; img[3] = 8'hC0;
    start_prog();
    finish_prog(0);

    // HALT holds with no stores
    clear_img();
    img[0] = 8'hC0;
    start_prog();
    finish_prog(20);

    // reset asserted while the LOAD is in its first data cycle
    clear_img();
    img[0] = 8'hA1; img[1] = 8'h80; img[2] = 8'h84; img[3] = 8'hE0;
    img[8'h80] = 8'h3C;
    start_prog();
    for (int i = 0; i < 100 && cyc < 5; i++) @(negedge clk);
    chk("ld1_addr", 32'(mem_addr), 32'h80);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'({mem_we, mem_addr}), 32'h0);
    clear_img();
    img[0] = 8'h84; img[1] = 8'hE0; img[2] = 8'hC0;
    img[8'hE0] = 8'h99;
    start_prog();
    finish_prog(0);
    chk("abort_r1_clear", 32'(mem[8'hE0]), 32'h00);

    // randomized programs
    for (int n = 0; n < 12; n++) begin
      gen_random();
      start_prog();
      finish_prog(0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
